// File: rtl/multdiv_if.sv
// Bundle between the E-stage sequencer, the surrounding pipeline control and
// the multiply/divide datapath.
//
// Handshake: req_valid/req_op/req_a/req_b describe the instruction sitting in
// E and stay stable while stall_e=1. The instruction leaves E on a cycle with
// advance_e=1 (and flush=0). flush kills the E instruction that cycle.
// dp_start is a single-cycle launch. dp_op/dp_a/dp_b are held until the next
// launch. dp_hi/dp_lo are sampled exactly LAT cycles after the launch cycle.
interface multdiv_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        advance_e;
  logic        flush;
  logic        stall_e;
  logic        dp_start;
  logic [1:0]  dp_op;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic [31:0] dp_hi;
  logic [31:0] dp_lo;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline/datapath side.
  modport master (
    output req_valid, req_op, req_a, req_b, advance_e, flush, dp_hi, dp_lo,
    input  stall_e, dp_start, dp_op, dp_a, dp_b, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, advance_e, flush, dp_hi, dp_lo,
    output stall_e, dp_start, dp_op, dp_a, dp_b, hi, lo
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer: launches the datapath, counts its latency,
// stalls E while a result is pending and owns the architectural HI/LO.
module multdiv_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  logic       clk,
  input  logic       reset,
  multdiv_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic [1:0]       dp_op_q;
  logic [31:0]      dp_a_q;
  logic [31:0]      dp_b_q;

  logic is_mul;
  logic is_div;
  logic is_mt;
  logic div_zero;
  logic launch;
  logic stall;

  // Decode the E instruction and derive the launch pulse and stall request.
  always_comb begin
    is_mul   = bus.req_valid && (bus.req_op == 3'd0 || bus.req_op == 3'd1);
    is_div   = bus.req_valid && (bus.req_op == 3'd2 || bus.req_op == 3'd3);
    is_mt    = bus.req_valid && (bus.req_op == 3'd4 || bus.req_op == 3'd5);
    div_zero = is_div && (bus.req_b == 32'd0);
    // A divide by zero never reaches the datapath; it just holds E one cycle.
    launch   = !reset && !bus.flush && (state == ST_IDLE) &&
               (is_mul || (is_div && !div_zero));
    stall    = !reset && !bus.flush &&
               (((state == ST_IDLE) && (is_mul || is_div)) || (state == ST_BUSY));
  end

  assign bus.dp_start = launch;
  assign bus.stall_e  = stall;
  assign bus.dp_op    = dp_op_q;
  assign bus.dp_a     = dp_a_q;
  assign bus.dp_b     = dp_b_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign dbg_state    = state;

  // Sequencer state, latency counter, launch operands and HI/LO updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      dp_op_q <= '0;
      dp_a_q  <= '0;
      dp_b_q  <= '0;
    end else if (bus.flush) begin
      // Killed instruction: abandon any in-flight op, never touch HI/LO.
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            dp_op_q <= bus.req_op[1:0];
            dp_a_q  <= bus.req_a;
            dp_b_q  <= bus.req_b;
            cnt     <= is_mul ? MUL_LOAD : DIV_LOAD;
            state   <= ST_BUSY;
          end else if (div_zero) begin
            // Result of a divide by zero is the current HI/LO.
            res_hi <= hi_q;
            res_lo <= lo_q;
            state  <= ST_DONE;
          end else if (is_mt && bus.advance_e) begin
            if (bus.req_op == 3'd4) begin
              hi_q <= bus.req_a;
            end else begin
              lo_q <= bus.req_a;
            end
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_hi <= bus.dp_hi;
            res_lo <= bus.dp_lo;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Result is committed only when the instruction actually leaves E.
          if (bus.advance_e) begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
